dram_refresh_ctrl: RTL and testbench

//  Parametrised single-port DRAM behavioural model with controller FSM.
//  - Valid/ready request interface; configurable read latency.
//  - Periodic auto-refresh timer that preempts new requests, multi-cycle refresh.
//  - Sits between a bus master and the storage array as the next-generation memory block for test SoCs.

---
 rtl/dram_pkg.sv | 17 +
 rtl/dram_refresh_timer.sv | 30 +++
 rtl/dram_refresh_ctrl.sv | 87 ++++++++
 tb/tb_dram_refresh_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// dram_pkg: shared FSM state encodings and width helper for the DRAM refresh controller
package dram_pkg;

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] READ    = 2'b01;
    localparam logic [1:0] WRITE   = 2'b10;
    localparam logic [1:0] REFRESH = 2'b11;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// dram_refresh_timer: free-running refresh interval counter raising ref_pending until refresh starts
module dram_refresh_timer
    import dram_pkg::*;
#(
    parameter int REF_INTERVAL = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ref_start,
    output logic ref_pending
);

    localparam int CNT_W = clog2(REF_INTERVAL);

    logic [CNT_W-1:0] count;
    logic             wrap;

    assign wrap = count == CNT_W'(REF_INTERVAL - 1);

    // count wraps every interval; a wrap raises the request, starting a refresh retires it
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            count       <= '0;
            ref_pending <= 1'b0;
        end else begin
            count       <= wrap ? '0 : count + 1'b1;
            ref_pending <= wrap ? 1'b1 : ref_start ? 1'b0 : ref_pending;
        end

endmodule

// File: rtl/dram_refresh_ctrl.sv
// dram_refresh_ctrl: single-port DRAM model with request FSM, read latency and periodic auto-refresh
module dram_refresh_ctrl
    import dram_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 4,
    parameter int RD_LAT       = 2,
    parameter int REF_INTERVAL = 64,
    parameter int REF_CYCLES   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              ref_pending,
    output logic [1:0]        curr_state
);

    localparam int PH_W = clog2(RD_LAT > REF_CYCLES ? RD_LAT : REF_CYCLES) + 1;

    logic [1:0]        state, next_state;
    logic [PH_W-1:0]   phase;
    logic              accept, ref_start, last_phase, read_done;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rd_sample;
    logic [DATA_W-1:0] mem [2**ADDR_W];

    dram_refresh_timer #(.REF_INTERVAL(REF_INTERVAL)) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .ref_start   (ref_start),
        .ref_pending (ref_pending)
    );

    assign curr_state = state;

    // state register; phase restarts on every state change and counts cycles spent in a state
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state <= IDLE;
            phase <= '0;
        end else begin
            state <= next_state;
            phase <= next_state == state ? phase + 1'b1 : '0;
        end

    // refresh wins over a waiting request; READ and REFRESH leave on their last phase
    always_comb
        next_state = state == IDLE  ? (ref_pending ? REFRESH : accept ? (req_we ? WRITE : READ) : IDLE) :
                     state == WRITE ? IDLE :
                     last_phase     ? IDLE : state;

    // handshake and phase decode
    always_comb begin
        req_ready  = state == IDLE && !ref_pending;
        accept     = req_valid && req_ready;
        ref_start  = state == IDLE && ref_pending;
        last_phase = phase == (state == READ ? PH_W'(RD_LAT - 1) : PH_W'(REF_CYCLES - 1));
        read_done  = state == READ && last_phase;
    end

    // read response pulses on the edge that returns the FSM to IDLE; data holds otherwise
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= read_done;
            if (read_done) rsp_rdata <= rd_sample;
        end

    // storage is never reset; a write commits only on the edge leaving WRITE, so reset drops it
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            rd_sample <= mem[req_addr];
        end
        if (state == WRITE) mem[addr_q] <= wdata_q;
    end

endmodule

// File: tb/tb_dram_refresh_ctrl.sv
// tb_dram_refresh_ctrl: directed and randomized checks against a time-window reference model
module tb_dram_refresh_ctrl;

    localparam int DATA_W       = 8;
    localparam int ADDR_W       = 4;
    localparam int RD_LAT       = 2;
    localparam int REF_INTERVAL = 64;
    localparam int REF_CYCLES   = 4;
    localparam logic [1:0] S_IDLE = 2'd0, S_READ = 2'd1, S_WRITE = 2'd2, S_REF = 2'd3;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              ref_pending;
    logic [1:0]        curr_state;

    int checks = 0;
    int errors = 0;

    dram_refresh_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT),
        .REF_INTERVAL(REF_INTERVAL), .REF_CYCLES(REF_CYCLES)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .ref_pending (ref_pending),
        .curr_state  (curr_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    req_t q[$];

    // reference model: operations occupy a window [accept+1, busy_end) of cycles after reset release
    logic [DATA_W-1:0] m_mem [2**ADDR_W];
    bit                m_known [2**ADDR_W];
    int                n, busy_end, rsp_at, wr_at;
    logic [1:0]        op;
    bit                pend, holding, accepted, rsp_k, exp_k;
    logic [DATA_W-1:0] rsp_d, exp_rdata, wr_d;
    logic [ADDR_W-1:0] wr_a;

    logic [DATA_W-1:0] rsp_log[$];
    int                rsp_cyc[$];
    int                ref_rise[$];
    int                ref_len[$];
    int                run_len;
    bit                prev_ref;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        n = 0; busy_end = 0; rsp_at = -1; wr_at = -1; op = S_IDLE;
        pend = 0; holding = 0; accepted = 0;
        exp_rdata = '0; exp_k = 1;
        prev_ref = 0; run_len = 0;
        q.delete(); ref_rise.delete(); ref_len.delete();
    endtask

    task automatic check_outputs();
        chk("curr_state", curr_state, n < busy_end ? op : S_IDLE);
        chk("req_ready", req_ready, n >= busy_end && !pend);
        chk("ref_pending", ref_pending, pend);
        chk("rsp_valid", rsp_valid, n == rsp_at);
        if (n == rsp_at) begin
            exp_rdata = rsp_d;
            exp_k     = rsp_k;
        end
        if (exp_k) chk("rsp_rdata", rsp_rdata, exp_rdata);
        if (rsp_valid) begin
            rsp_log.push_back(rsp_rdata);
            rsp_cyc.push_back(n);
        end
        if (ref_pending && !prev_ref) ref_rise.push_back(n);
        prev_ref = ref_pending;
        if (curr_state == S_REF) run_len++;
        else if (run_len > 0) begin
            ref_len.push_back(run_len);
            run_len = 0;
        end
    endtask

    task automatic drive();
        req_t r;
        if (!holding && q.size() > 0) begin
            r = q.pop_front();
            req_we = r.we; req_addr = r.addr; req_wdata = r.data;
            holding = 1;
        end else if (!holding) begin
            req_we = 1'($urandom); req_addr = ADDR_W'($urandom); req_wdata = DATA_W'($urandom);
        end
        req_valid = holding;
    endtask

    task automatic model_edge();
        accepted = 0;
        if (n >= busy_end && pend) begin
            op = S_REF; busy_end = n + 1 + REF_CYCLES; pend = 0;
        end else if (n >= busy_end && req_valid) begin
            accepted = 1;
            if (req_we) begin
                op = S_WRITE; busy_end = n + 2; wr_at = n + 2; wr_a = req_addr; wr_d = req_wdata;
            end else begin
                op = S_READ; busy_end = n + 1 + RD_LAT; rsp_at = n + 1 + RD_LAT;
                rsp_d = m_mem[req_addr]; rsp_k = m_known[req_addr];
            end
        end
        n++;
        if (n == wr_at) begin
            m_mem[wr_a]   = wr_d;
            m_known[wr_a] = 1;
        end
        if (n % REF_INTERVAL == 0) pend = 1;
        if (accepted) holding = 0;
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        drive();
        model_edge();
    endtask

    task automatic do_reset(input bit chk_pre, input logic [1:0] pre);
        @(posedge clk);
        #1;
        if (chk_pre) chk("pre_reset_state", curr_state, pre);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_state", curr_state, S_IDLE);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_ref_pending", ref_pending, 0);
        req_valid = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    function automatic req_t mk(input logic we, input int addr, input int data);
        req_t r;
        r.we = we; r.addr = ADDR_W'(addr); r.data = DATA_W'(data);
        return r;
    endfunction

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) m_known[i] = 0;
        do_reset(0, S_IDLE);

        // idle: refresh requests at 64 and 128, each refresh REF_CYCLES long
        while (n < 135) step();
        chk("ref_rise_cnt", ref_rise.size(), 2);
        if (ref_rise.size() == 2) begin
            chk("ref_rise_1", ref_rise[0], 64);
            chk("ref_rise_2", ref_rise[1], 128);
        end
        chk("ref_len_cnt", ref_len.size(), 2);
        if (ref_len.size() > 0) chk("ref_len", ref_len[0], REF_CYCLES);

        // write/read same address, top address does not alias address 0
        rsp_log.delete(); rsp_cyc.delete();
        q.push_back(mk(1, 3, 'hA5));
        q.push_back(mk(0, 3, 0));
        q.push_back(mk(1, 0, 'h5A));
        q.push_back(mk(1, 15, 'h3C));
        q.push_back(mk(0, 15, 0));
        q.push_back(mk(0, 0, 0));
        repeat (30) step();
        chk("wr_rd_cnt", rsp_log.size(), 3);
        if (rsp_log.size() == 3) begin
            chk("rd_addr3", rsp_log[0], 'hA5);
            chk("rd_addr15", rsp_log[1], 'h3C);
            chk("rd_addr0", rsp_log[2], 'h5A);
        end

        // read held while refresh becomes due: refresh first, then the read
        while (n < 3 * REF_INTERVAL) step();
        rsp_log.delete(); rsp_cyc.delete();
        q.push_back(mk(0, 0, 0));
        repeat (12) step();
        chk("ref_then_rd_cnt", rsp_log.size(), 1);
        if (rsp_log.size() == 1) begin
            chk("ref_then_rd_data", rsp_log[0], 'h5A);
            chk("ref_then_rd_cycle", rsp_cyc[0], 3 * REF_INTERVAL + 1 + REF_CYCLES + 1 + RD_LAT);
        end

        // reset in the first READ cycle: no response ever appears
        q.push_back(mk(0, 3, 0));
        for (int i = 0; i < 20 && !accepted; i++) step();
        chk("rd_accept_seen", accepted, 1);
        do_reset(1, S_READ);
        rsp_log.delete();
        repeat (10) step();
        chk("rsp_after_rst", rsp_log.size(), 0);

        // reset in the WRITE cycle drops the write
        q.push_back(mk(1, 7, 'h22));
        repeat (6) step();
        q.push_back(mk(1, 7, 'h11));
        for (int i = 0; i < 20 && !accepted; i++) step();
        chk("wr_accept_seen", accepted, 1);
        do_reset(1, S_WRITE);
        rsp_log.delete();
        q.push_back(mk(0, 7, 0));
        repeat (8) step();
        chk("drop_wr_cnt", rsp_log.size(), 1);
        if (rsp_log.size() == 1) chk("drop_wr_data", rsp_log[0], 'h22);

        // randomized traffic across refreshes
        for (int i = 0; i < 1500; i++) begin
            if (q.size() == 0 && $urandom_range(0, 2) == 0)
                q.push_back(mk(1'($urandom), int'($urandom_range(0, 2**ADDR_W - 1)), int'($urandom_range(0, 255))));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
